// File: rtl/key_event_pkg.sv
// Shared types for the key press-event controller: event codes, per-key FSM
// states and the queued event record.
package key_event_pkg;

    typedef enum logic [1:0] {
        EV_SHORT   = 2'd0,
        EV_LONG    = 2'd1,
        EV_REPEAT  = 2'd2,
        EV_RELEASE = 2'd3
    } evt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_REPT = 2'd2
    } key_st_e;

    // Wide enough for the largest supported key count (16 keys).
    localparam int KEY_IDX_W = 4;

    typedef struct packed {
        logic [KEY_IDX_W-1:0] key;
        evt_e                 typ;
    } evt_rec_t;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_event_fsm.sv
// One key's press classifier (IDLE/HELD/REPT with tick-driven hold counter)
// and its one-entry pending event slot.
module key_event_fsm
    import key_event_pkg::*;
#(
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic key_lvl_i,
    input  logic grant_i,
    output logic pend_o,
    output evt_e pend_type_o,
    output logic drop_o
);

    localparam int CNT_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] REPT_LAST = CW'(REPEAT_TICKS - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

    key_st_e       state_q;
    logic [CW-1:0] cnt_q;
    logic          emit_q;
    evt_e          emit_type_q;
    logic          pend_q;
    evt_e          pend_type_q;
    logic          load;

    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
        return (c == CNT_SAT) ? c : c + 1'b1;
    endfunction

    // A release seen on a threshold tick wins: only SHORT/RELEASE is emitted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            emit_q      <= 1'b0;
            emit_type_q <= EV_SHORT;
        end else begin
            emit_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (key_lvl_i) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                    end
                end
                ST_HELD: begin
                    if (!key_lvl_i) begin
                        state_q     <= ST_IDLE;
                        emit_q      <= 1'b1;
                        emit_type_q <= EV_SHORT;
                    end else if (tick_i) begin
                        if (cnt_q == LONG_LAST) begin
                            state_q     <= ST_REPT;
                            cnt_q       <= '0;
                            emit_q      <= 1'b1;
                            emit_type_q <= EV_LONG;
                        end else begin
                            cnt_q <= cnt_inc(cnt_q);
                        end
                    end
                end
                ST_REPT: begin
                    if (!key_lvl_i) begin
                        state_q     <= ST_IDLE;
                        emit_q      <= 1'b1;
                        emit_type_q <= EV_RELEASE;
                    end else if (tick_i) begin
                        if (cnt_q == REPT_LAST) begin
                            cnt_q       <= '0;
                            emit_q      <= 1'b1;
                            emit_type_q <= EV_REPEAT;
                        end else begin
                            cnt_q <= cnt_inc(cnt_q);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A slot being granted this cycle is free for a new event on the same edge.
    assign drop_o = emit_q && pend_q && !grant_i;
    assign load   = emit_q && !drop_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
        end else if (load) begin
            pend_q <= 1'b1;
        end else if (grant_i) begin
            pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load) begin
            pend_type_q <= emit_type_q;
        end
    end

    assign pend_o      = pend_q;
    assign pend_type_o = pend_type_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Multi-key press-event controller: shared tick, per-key classifiers,
// round-robin slot scheduler and a first-word-fall-through event queue.
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int KEY_NUM      = 4,
    parameter int TICK_DIV     = 10,
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter int FIFO_DEPTH   = 4,
    localparam int KW          = idx_w(KEY_NUM)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [KEY_NUM-1:0] key_lvl_i,
    output logic               evt_valid_o,
    input  logic               evt_ready_i,
    output logic [KW-1:0]      evt_key_o,
    output evt_e               evt_type_o,
    output logic               ovf_o,
    input  logic               ovf_clr_i
);

    localparam int TW   = idx_w(TICK_DIV);
    localparam int AW   = idx_w(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

    logic [TW-1:0]      tick_q;
    logic               tick;
    logic [KEY_NUM-1:0] pend;
    logic [KEY_NUM-1:0] drop;
    logic [KEY_NUM-1:0] grant_vec;
    evt_e               pend_type [KEY_NUM];
    logic [KW-1:0]      last_q;
    logic [KW-1:0]      gnt_idx;
    logic [KW:0]        cand;
    logic               gnt_any;
    evt_rec_t           mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [CNTW-1:0]    count_q;
    logic               push;
    logic               pop;
    logic               can_push;
    logic               ovf_q;
    evt_rec_t           head;
    logic               unused_key_bits;

    assign tick = (tick_q == TICK_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick ? '0 : tick_q + 1'b1;
        end
    end

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        key_event_fsm #(
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_fsm (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .tick_i     (tick),
            .key_lvl_i  (key_lvl_i[k]),
            .grant_i    (grant_vec[k]),
            .pend_o     (pend[k]),
            .pend_type_o(pend_type[k]),
            .drop_o     (drop[k])
        );
    end

    // A pop frees a slot on the same edge, so a full queue still accepts a push.
    assign pop      = evt_valid_o && evt_ready_i;
    assign can_push = (count_q != FULL_CNT) || pop;

    // Round-robin search starting just after the most recently granted key.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (can_push) begin
            for (int i = 1; i <= KEY_NUM; i++) begin
                cand = {1'b0, last_q} + (KW+1)'(i);
                if (cand >= (KW+1)'(KEY_NUM)) begin
                    cand = cand - (KW+1)'(KEY_NUM);
                end
                if (!gnt_any && pend[cand[KW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[KW-1:0];
                end
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (gnt_any) begin
            grant_vec[gnt_idx] = 1'b1;
        end
    end

    assign push = gnt_any;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= KW'(KEY_NUM - 1);
        end else if (gnt_any) begin
            last_q <= gnt_idx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{key: KEY_IDX_W'(gnt_idx), typ: pend_type[gnt_idx]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
        end else if (|drop) begin
            ovf_q <= 1'b1;
        end
    end

    // Head is masked while empty so the outputs read zero out of reset.
    assign head            = mem_q[rd_ptr_q];
    assign unused_key_bits = ^head.key;
    assign evt_valid_o     = (count_q != '0);
    assign evt_key_o       = evt_valid_o ? head.key[KW-1:0] : '0;
    assign evt_type_o      = evt_valid_o ? head.typ : EV_SHORT;
    assign ovf_o           = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Randomised scoreboard bench for key_event_ctrl with a hold-time based
// reference model of press classification, slot, scheduler and queue.
module tb_key_event_ctrl;
    import key_event_pkg::*;

    localparam int KEY_NUM      = 2;
    localparam int TICK_DIV     = 4;
    localparam int LONG_TICKS   = 5;
    localparam int REPEAT_TICKS = 3;
    localparam int FIFO_DEPTH   = 4;
    localparam int KW           = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [KEY_NUM-1:0] key_lvl = '0;
    logic               evt_ready = 1'b1;
    logic               ovf_clr = 1'b0;
    logic               evt_valid;
    logic [KW-1:0]      evt_key;
    logic [1:0]         evt_type;
    logic               ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int key;
        int typ;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: hold time in ticks since the press was seen.
    int m_tc, m_cnt, m_last, m_ovf;
    int m_press [KEY_NUM];
    int m_ht    [KEY_NUM];
    int m_slot_v[KEY_NUM];
    int m_slot_t[KEY_NUM];
    int m_em_v  [KEY_NUM];
    int m_em_t  [KEY_NUM];

    key_event_ctrl #(
        .KEY_NUM     (KEY_NUM),
        .TICK_DIV    (TICK_DIV),
        .LONG_TICKS  (LONG_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .key_lvl_i  (key_lvl),
        .evt_valid_o(evt_valid),
        .evt_ready_i(evt_ready),
        .evt_key_o  (evt_key),
        .evt_type_o (evt_type),
        .ovf_o      (ovf),
        .ovf_clr_i  (ovf_clr)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            if (errors <= 40) begin
                $display("FAIL %s actual=%0d required=%0d", name, act, req);
            end
        end
    endfunction

    function automatic void model_reset();
        m_tc   = 0;
        m_cnt  = 0;
        m_last = KEY_NUM - 1;
        m_ovf  = 0;
        for (int k = 0; k < KEY_NUM; k++) begin
            m_press[k]  = 0;
            m_ht[k]     = 0;
            m_slot_v[k] = 0;
            m_slot_t[k] = 0;
            m_em_v[k]   = 0;
            m_em_t[k]   = 0;
        end
        exp_q.delete();
    endfunction

    function automatic void model_step();
        int   nev_v[KEY_NUM];
        int   nev_t[KEY_NUM];
        int   tick, pop, can_push, g, k, drop;
        exp_t e;
        tick     = (m_tc == TICK_DIV - 1);
        pop      = (m_cnt > 0) && evt_ready;
        can_push = (m_cnt < FIFO_DEPTH) || pop;
        g        = -1;
        drop     = 0;
        m_tc     = tick ? 0 : m_tc + 1;
        for (int i = 0; i < KEY_NUM; i++) begin
            nev_v[i] = 0;
            nev_t[i] = 0;
            if (!m_press[i]) begin
                if (key_lvl[i]) begin
                    m_press[i] = 1;
                    m_ht[i]    = 0;
                end
            end else if (!key_lvl[i]) begin
                nev_v[i]   = 1;
                nev_t[i]   = (m_ht[i] < LONG_TICKS) ? int'(EV_SHORT) : int'(EV_RELEASE);
                m_press[i] = 0;
            end else if (tick) begin
                m_ht[i]++;
                if (m_ht[i] == LONG_TICKS) begin
                    nev_v[i] = 1;
                    nev_t[i] = int'(EV_LONG);
                end else if (m_ht[i] > LONG_TICKS && (m_ht[i] - LONG_TICKS) % REPEAT_TICKS == 0) begin
                    nev_v[i] = 1;
                    nev_t[i] = int'(EV_REPEAT);
                end
            end
        end
        if (can_push) begin
            for (int i = 1; i <= KEY_NUM; i++) begin
                k = (m_last + i) % KEY_NUM;
                if (g < 0 && m_slot_v[k]) g = k;
            end
        end
        if (pop) m_cnt--;
        if (g >= 0) begin
            e.key = g;
            e.typ = m_slot_t[g];
            exp_q.push_back(e);
            m_cnt++;
            m_slot_v[g] = 0;
            m_last      = g;
        end
        for (int i = 0; i < KEY_NUM; i++) begin
            if (m_em_v[i]) begin
                if (m_slot_v[i]) begin
                    drop = 1;
                end else begin
                    m_slot_v[i] = 1;
                    m_slot_t[i] = m_em_t[i];
                end
            end
            m_em_v[i] = nev_v[i];
            m_em_t[i] = nev_t[i];
        end
        if (ovf_clr) m_ovf = 0;
        else if (drop) m_ovf = 1;
    endfunction

    always @(posedge clk) begin
        if (!rst) model_step();
    end

    // Monitor: compares the presented head against the scoreboard on each handshake.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            chk("evt_valid", int'(evt_valid), int'(m_cnt > 0));
            chk("ovf", int'(ovf), m_ovf);
            if (evt_valid && evt_ready) begin
                chk("evt_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("evt_key", int'(evt_key), e.key);
                    chk("evt_type", int'(evt_type), e.typ);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!evt_valid && n < 100);
    endtask

    initial begin
        int n;
        model_reset();
        #1;
        chk("reset_valid", int'(evt_valid), 0);
        chk("reset_key", int'(evt_key), 0);
        chk("reset_type", int'(evt_type), int'(EV_SHORT));
        chk("reset_ovf", int'(ovf), 0);
        cyc(2);
        rst = 1'b0;

        // Short press with release-to-valid latency.
        key_lvl[0] = 1'b1;
        cyc(3 * TICK_DIV);
        key_lvl[0] = 1'b0;
        wait_valid(n);
        chk("short_latency", n, 3);
        chk("short_key", int'(evt_key), 0);
        chk("short_type", int'(evt_type), int'(EV_SHORT));
        cyc(6);

        // Long hold on key1 with repeats and release.
        key_lvl[1] = 1'b1;
        cyc(12 * TICK_DIV);
        key_lvl[1] = 1'b0;
        cyc(10);

        // Simultaneous releases, twice back to back.
        repeat (2) begin
            key_lvl = '1;
            cyc(2 * TICK_DIV);
            key_lvl = '0;
            cyc(8);
        end

        // Overflow with the consumer stalled.
        evt_ready = 1'b0;
        repeat (6) begin
            key_lvl[0] = 1'b1;
            cyc(2);
            key_lvl[0] = 1'b0;
            cyc(3);
        end
        cyc(3);
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_full_valid", int'(evt_valid), 1);
        evt_ready = 1'b1;
        cyc(12);
        chk("ovf_sticky", int'(ovf), 1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        #1;
        chk("ovf_cleared", int'(ovf), 0);
        cyc(6);

        // Release landing exactly on the LONG threshold tick.
        key_lvl[0] = 1'b1;
        n = 0;
        while (!(m_press[0] && m_ht[0] == LONG_TICKS - 1 && m_tc == TICK_DIV - 1) && n < 100) begin
            cyc(1);
            n++;
        end
        chk("collision_align", int'(n < 100), 1);
        key_lvl[0] = 1'b0;
        wait_valid(n);
        chk("collision_type", int'(evt_type), int'(EV_SHORT));
        cyc(8);

        // Reset while key1 repeats with two events queued.
        evt_ready  = 1'b0;
        key_lvl[1] = 1'b1;
        n = 0;
        while (m_cnt < 2 && n < 200) begin
            cyc(1);
            n++;
        end
        chk("rst_setup", int'(evt_valid) + n / 200, 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_async_valid", int'(evt_valid), 0);
        chk("rst_async_ovf", int'(ovf), 0);
        cyc(2);
        rst       = 1'b0;
        evt_ready = 1'b1;
        wait_valid(n);
        // Press sampled on the first edge, LONG on the fifth tick, then two stages.
        chk("rst_long_latency", n, LONG_TICKS * TICK_DIV + 2);
        chk("rst_long_key", int'(evt_key), 1);
        chk("rst_long_type", int'(evt_type), int'(EV_LONG));
        key_lvl[1] = 1'b0;
        cyc(10);

        // Randomised traffic in three behaviour modes.
        for (int i = 0; i < 3600; i++) begin
            int mode;
            mode = (i / 400) % 3;
            for (int k = 0; k < KEY_NUM; k++) begin
                case (mode)
                    0: if ($urandom_range(0, 15) == 0) key_lvl[k] = ~key_lvl[k];
                    1: if ($urandom_range(0, 2) == 0) key_lvl[k] = ~key_lvl[k];
                    default: if ($urandom_range(0, 39) == 0) key_lvl[k] = ~key_lvl[k];
                endcase
            end
            case (mode)
                0: evt_ready = ($urandom_range(0, 3) != 0);
                1: evt_ready = ($urandom_range(0, 3) == 0);
                default: evt_ready = 1'b1;
            endcase
            ovf_clr = ($urandom_range(0, 63) == 0);
            cyc(1);
        end

        // Drain everything still in flight.
        key_lvl   = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        cyc(10);
        n = 0;
        while ((exp_q.size() != 0 || m_cnt != 0) && n < 200) begin
            cyc(1);
            n++;
        end
        cyc(2);
        #2;
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_valid", int'(evt_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
